// File: rtl/fp_pkg.sv
// Shared operand/result types and helpers for the floating-point add/sub datapath.
// The struct typedefs describe the default single-precision field layout.
package fp_pkg;

   localparam int GRS_W     = 3;
   localparam int FP_EXP_W  = 8;
   localparam int FP_MANT_W = 23;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_MANT_W-1:0] mant;
   } fp_op_t;

   typedef struct packed {
      logic                 big_sign;
      logic [FP_EXP_W-1:0]  big_exp;
      logic [FP_MANT_W:0]   big_sig;
      logic [FP_MANT_W:0]   small_sig;
      logic [GRS_W-1:0]     small_grs;
      logic                 eff_sub;
      logic                 swapped;
   } fp_pair_t;

   // Normal numbers carry an implicit leading one; denormals and zero do not.
   function automatic logic hidden_bit(input logic [31:0] exp);
      return |exp;
   endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Log-stage right barrel shifter with sticky collection for significand alignment.
// FP_SWAP_GRS_EN adds three guard/round/sticky bits below the significand.
module fp_align_shift
   import fp_pkg::*;
#(
   parameter int SIG_W = 24,
   parameter int SH_W  = 8
) (
   input  logic [SIG_W-1:0] i_sig,
   input  logic [SH_W-1:0]  i_sh,
   output logic [SIG_W-1:0] o_sig,
   output logic [GRS_W-1:0] o_grs
);

`ifdef FP_SWAP_GRS_EN
   localparam int XB = GRS_W;
`else
   localparam int XB = 0;
`endif
   localparam int W = SIG_W + XB;
   localparam int L = $clog2(W + 1);

   logic [L-1:0] w_amt;
   logic [W-1:0] w_stg [0:L];

   // Any shift of W or more empties the datapath, so clamp to W.
   assign w_amt    = (32'(i_sh) >= W) ? L'(W) : L'(i_sh);
   assign w_stg[0] = W'(i_sig) << XB;

   for (genvar k = 0; k < L; k++) begin : g_stg
      assign w_stg[k+1] = w_amt[k] ? (w_stg[k] >> (2**k)) : w_stg[k];
   end

`ifdef FP_SWAP_GRS_EN
   logic [L:0] w_lost;
   assign w_lost[0] = 1'b0;
   for (genvar k = 0; k < L; k++) begin : g_lost
      assign w_lost[k+1] = w_lost[k] | (w_amt[k] & (|w_stg[k][(2**k)-1:0]));
   end
   assign o_grs = {w_stg[L][2:1], w_stg[L][0] | w_lost[L]};
`else
   assign o_grs = '0;
`endif

   assign o_sig = w_stg[L][W-1 -: SIG_W];

endmodule

// File: rtl/fp_swap_align.sv
// Swap-and-align stage: orders operands by magnitude, aligns the smaller significand.
// Two-stage valid/ready pipeline; guard/round/sticky output enabled by FP_SWAP_GRS_EN.
module fp_swap_align
   import fp_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sign_A,
   input  logic              sign_B,
   input  logic [EXP_W-1:0]  exp_A,
   input  logic [EXP_W-1:0]  exp_B,
   input  logic [MANT_W-1:0] mant_A,
   input  logic [MANT_W-1:0] mant_B,
   input  logic              sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              big_sign,
   output logic [EXP_W-1:0]  big_exp,
   output logic [MANT_W:0]   big_sig,
   output logic [MANT_W:0]   small_sig,
   output logic [GRS_W-1:0]  small_grs,
   output logic              eff_sub,
   output logic              swapped
);

   localparam int SIG_W = MANT_W + 1;

   typedef struct packed {
      logic             big_sign;
      logic [EXP_W-1:0] big_exp;
      logic [SIG_W-1:0] big_sig;
      logic [SIG_W-1:0] small_sig;
      logic [EXP_W-1:0] diff;
      logic             eff_sub;
      logic             swapped;
   } s1_t;

   typedef struct packed {
      logic             big_sign;
      logic [EXP_W-1:0] big_exp;
      logic [SIG_W-1:0] big_sig;
      logic [SIG_W-1:0] small_sig;
      logic [GRS_W-1:0] small_grs;
      logic             eff_sub;
      logic             swapped;
   } s2_t;

   logic             w_sB;
   logic             w_swap;
   logic [EXP_W-1:0] w_eA;
   logic [EXP_W-1:0] w_eB;
   logic [SIG_W-1:0] w_sigA;
   logic [SIG_W-1:0] w_sigB;
   s1_t              w_s1;
   s2_t              w_s2;
   logic [SIG_W-1:0] w_sh_sig;
   logic [GRS_W-1:0] w_sh_grs;
   logic             w_s1_adv;
   logic             w_s2_adv;

   logic [2:1]       r_vld;
   s1_t              r_s1;
   s2_t              r_s2;

   assign w_sB   = sign_B ^ sub;
   assign w_swap = {exp_B, mant_B} > {exp_A, mant_A};
   // Denormals share the minimum exponent with exp=1 for alignment.
   assign w_eA   = (exp_A == '0) ? EXP_W'(1) : exp_A;
   assign w_eB   = (exp_B == '0) ? EXP_W'(1) : exp_B;
   assign w_sigA = {hidden_bit(32'(exp_A)), mant_A};
   assign w_sigB = {hidden_bit(32'(exp_B)), mant_B};

   always_comb begin
      w_s1         = '0;
      w_s1.eff_sub = sign_A ^ w_sB;
      w_s1.swapped = w_swap;
      if (w_swap) begin
         w_s1.big_sign  = w_sB;
         w_s1.big_exp   = exp_B;
         w_s1.big_sig   = w_sigB;
         w_s1.small_sig = w_sigA;
         w_s1.diff      = w_eB - w_eA;
      end else begin
         w_s1.big_sign  = sign_A;
         w_s1.big_exp   = exp_A;
         w_s1.big_sig   = w_sigA;
         w_s1.small_sig = w_sigB;
         w_s1.diff      = w_eA - w_eB;
      end
   end

   fp_align_shift #(
      .SIG_W (SIG_W),
      .SH_W  (EXP_W)
   ) u_shift (
      .i_sig (r_s1.small_sig),
      .i_sh  (r_s1.diff),
      .o_sig (w_sh_sig),
      .o_grs (w_sh_grs)
   );

   always_comb begin
      w_s2           = '0;
      w_s2.big_sign  = r_s1.big_sign;
      w_s2.big_exp   = r_s1.big_exp;
      w_s2.big_sig   = r_s1.big_sig;
      w_s2.small_sig = w_sh_sig;
      w_s2.small_grs = w_sh_grs;
      w_s2.eff_sub   = r_s1.eff_sub;
      w_s2.swapped   = r_s1.swapped;
   end

   assign w_s2_adv = !r_vld[2] || out_ready;
   assign w_s1_adv = !r_vld[1] || w_s2_adv;
   // Reset empties the pipe, so the stage is ready while reset is held.
   assign in_ready = w_s1_adv || rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_s1  <= '0;
         r_s2  <= '0;
      end else begin
         if (w_s1_adv) begin
            r_vld[1] <= in_valid;
            if (in_valid) r_s1 <= w_s1;
         end
         if (w_s2_adv) begin
            r_vld[2] <= r_vld[1];
            if (r_vld[1]) r_s2 <= w_s2;
         end
      end
   end

   assign out_valid = r_vld[2];
   assign big_sign  = r_s2.big_sign;
   assign big_exp   = r_s2.big_exp;
   assign big_sig   = r_s2.big_sig;
   assign small_sig = r_s2.small_sig;
   assign small_grs = r_s2.small_grs;
   assign eff_sub   = r_s2.eff_sub;
   assign swapped   = r_s2.swapped;

endmodule

// File: tb/tb_fp_swap_align.sv
// Directed bench for fp_swap_align: single ops, alignment boundaries, stalled stream, reset flush.
module tb_fp_swap_align;
   import fp_pkg::*;

`ifdef FP_SWAP_GRS_EN
   localparam bit G = 1'b1;
`else
   localparam bit G = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, sign_A, sign_B, sub;
   logic        out_valid, out_ready, big_sign, eff_sub, swapped;
   logic [7:0]  exp_A, exp_B, big_exp;
   logic [22:0] mant_A, mant_B;
   logic [23:0] big_sig, small_sig;
   logic [2:0]  small_grs;
   fp_pair_t    obs, held;
   int          checks = 0;
   int          errors = 0;
   int          tx, rx;
   logic        acc;

   always #5 clk = ~clk;

   fp_swap_align dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
      .mant_A(mant_A), .mant_B(mant_B), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .big_sign(big_sign), .big_exp(big_exp), .big_sig(big_sig),
      .small_sig(small_sig), .small_grs(small_grs), .eff_sub(eff_sub), .swapped(swapped)
   );

   assign obs = {big_sign, big_exp, big_sig, small_sig, small_grs, eff_sub, swapped};

   function automatic fp_op_t op(input logic s, input logic [7:0] e, input logic [22:0] m);
      return {s, e, m};
   endfunction

   function automatic fp_pair_t mk(input logic bs, input logic [7:0] be, input logic [23:0] bsig,
                                   input logic [23:0] ssig, input logic [2:0] grs,
                                   input logic es, input logic sw);
      return {bs, be, bsig, ssig, grs, es, sw};
   endfunction

   task automatic chk_pair(input string tag, input fp_pair_t o, input fp_pair_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic chk_int(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input fp_op_t a, input fp_op_t b, input logic s);
      sign_A = a.sign; exp_A = a.exp; mant_A = a.mant;
      sign_B = b.sign; exp_B = b.exp; mant_B = b.mant;
      sub = s;
   endtask

   task automatic run_one(input string tag, input fp_op_t a, input fp_op_t b, input logic s,
                          input fp_pair_t e);
      set_ops(a, b, s);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk_int({tag, "_lat1"}, int'(out_valid), 0);
      tick;
      chk_int({tag, "_vld"}, int'(out_valid), 1);
      chk_pair(tag, obs, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_ops(op(0, 8'h00, 23'h0), op(0, 8'h00, 23'h0), 1'b0);
      tick; tick;
      chk_int("reset_ovld", int'(out_valid), 0);
      chk_int("reset_in_ready", int'(in_ready), 1);
      chk_pair("reset_data", obs, '0);
      rst = 1'b0;

      run_one("add_noswap", op(0, 8'h81, 23'h5CCCCD), op(0, 8'h81, 23'h066666), 1'b0,
              mk(0, 8'h81, 24'hDCCCCD, 24'h866666, 3'b000, 0, 0));
      run_one("add_swap", op(0, 8'h7E, 23'h30A3D7), op(0, 8'h81, 23'h066666), 1'b0,
              mk(0, 8'h81, 24'h866666, 24'h16147A, G ? 3'b111 : 3'b000, 0, 1));
      run_one("sub_swap", op(0, 8'h7E, 23'h30A3D7), op(0, 8'h81, 23'h066666), 1'b1,
              mk(1, 8'h81, 24'h866666, 24'h16147A, G ? 3'b111 : 3'b000, 1, 1));
      run_one("far_shift", op(0, 8'hFE, 23'h0), op(0, 8'h01, 23'h123456), 1'b0,
              mk(0, 8'hFE, 24'h800000, 24'h0, G ? 3'b001 : 3'b000, 0, 0));
      run_one("equal_mag", op(0, 8'h80, 23'h400000), op(1, 8'h80, 23'h400000), 1'b0,
              mk(0, 8'h80, 24'hC00000, 24'hC00000, 3'b000, 1, 0));
      run_one("denorm", op(0, 8'h02, 23'h0), op(0, 8'h00, 23'h000007), 1'b0,
              mk(0, 8'h02, 24'h800000, 24'h000003, G ? 3'b100 : 3'b000, 0, 0));
      run_one("shift24", op(0, 8'h99, 23'h0), op(1, 8'h81, 23'h000001), 1'b1,
              mk(0, 8'h99, 24'h800000, 24'h0, G ? 3'b101 : 3'b000, 0, 0));
      run_one("neg_swap", op(1, 8'h80, 23'h0), op(0, 8'h82, 23'h200000), 1'b1,
              mk(1, 8'h82, 24'hA00000, 24'h200000, 3'b000, 0, 1));
      run_one("zero_a", op(0, 8'h00, 23'h0), op(0, 8'h85, 23'h0), 1'b0,
              mk(0, 8'h85, 24'h800000, 24'h0, 3'b000, 0, 1));
      tick;

      // Stream of 8 pairs with out_ready low for cycles 4..6.
      tx = 0; rx = 0;
      for (int c = 0; c < 40 && rx < 8; c++) begin
         out_ready = !(c >= 4 && c <= 6);
         in_valid  = (tx < 8);
         set_ops(op(0, 8'h90, 23'h0), op(0, 8'h88, 23'(tx) << 20), 1'b0);
         #1;
         if (c >= 4 && c <= 6) chk_int("stall_in_ready", int'(in_ready), 0);
         if (c == 4) begin
            chk_int("stall_ovld", int'(out_valid), 1);
            held = obs;
         end
         if (c == 5 || c == 6) chk_pair("stall_hold", obs, held);
         if (out_valid && out_ready) begin
            chk_pair($sformatf("stream%0d", rx), obs,
                     mk(0, 8'h90, 24'h800000, 24'h008000 + (24'(rx) << 12), 3'b000, 0, 0));
            rx++;
         end
         acc = in_valid && in_ready;
         tick;
         if (acc) tx++;
      end
      in_valid = 1'b0;
      chk_int("stream_rx", rx, 8);
      chk_int("stream_tx", tx, 8);

      // Fill both stages, then reset mid-flight.
      out_ready = 1'b0; in_valid = 1'b1;
      set_ops(op(0, 8'h81, 23'h5CCCCD), op(0, 8'h81, 23'h066666), 1'b0);
      tick; tick;
      chk_int("full_in_ready", int'(in_ready), 0);
      rst = 1'b1;
      #1;
      chk_int("rst_in_ready_during", int'(in_ready), 1);
      tick;
      chk_int("rst_ovld", int'(out_valid), 0);
      chk_pair("rst_data", obs, '0);
      chk_int("rst_in_ready", int'(in_ready), 1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick;
      chk_int("rst_flush1", int'(out_valid), 0);
      tick;
      chk_int("rst_flush2", int'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_swap_align.md
# fp_swap_align

Parametrised, pipelined operand swap-and-align stage for the floating-point adder/subtracter datapath. It accepts two unpacked operands (sign, exponent, mantissa) plus an add/subtract command. It orders them so the larger magnitude is operand A, and right-shifts the smaller operand's significand by the exponent difference. The result feeds the mantissa add/normalise stage. It supersedes the single-precision combinational swap with configurable widths, a two-stage pipeline, valid/ready flow control and guard/round/sticky generation.

## Interface
- EXP_W, 8, exponent field width
- MANT_W, 23, stored mantissa field width (hidden bit excluded)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept operands this cycle
- sign_A, sign_B  in  1  operand signs
- exp_A, exp_B  in  EXP_W  biased exponents
- mant_A, mant_B  in  MANT_W  stored mantissas
- sub  in  1  1 = A − B, 0 = A + B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- big_sign  out  1  sign of larger-magnitude operand (after sub applied to B)
- big_exp  out  EXP_W  exponent of larger operand, the result's provisional exponent
- big_sig  out  MANT_W+1  larger significand including hidden bit
- small_sig  out  MANT_W+1  aligned smaller significand
- small_grs  out  3  guard, round, sticky bits shifted out of small_sig
- eff_sub  out  1  effective operation is subtraction
- swapped  out  1  operands were exchanged

## Operation
- Effective B sign: sB = sign_B ^ sub. eff_sub = sign_A ^ sB.
- Magnitude compare uses the concatenation {exp, mant}, unsigned.
- Swap only if B's magnitude > A's magnitude. Equal magnitudes: no swap, swapped = 0.
- When swapped, big_sign = sB. Otherwise big_sign = sign_A.
- Hidden bit = 1 if exp ≠ 0, else 0.
- Denormal handling: an exponent of 0 is treated as 1 for the difference calculation.
- Stage 1 (S1) registers the ordered operands, eff_sub, swapped, and the difference d = exp_big − exp_small. d is EXP_W bits and always ≥ 0.
- Stage 2 (S2) right-shifts the small significand extended by 3 zero bits: {sig, 3'b000} >> min(d, MANT_W+4).
  - The sticky bit is the OR of every bit shifted past bit 0, plus the original bit 0.
  - If d ≥ MANT_W+4, small_sig = 0 and grs = {0, 0, |sig}.
- Zero operands pass through without special casing: the zero is always the smaller operand, or both are zero.

## Timing
- Latency is 2 cycles from an accepted input (in_valid & in_ready) to out_valid.
- Throughput is 1 operand pair per cycle when out_ready stays high.
- S2 advances when !s2_valid | out_ready. S1 advances when !s1_valid | S2 advance. in_ready equals the S1 advance condition.
- in_ready is combinational from out_ready. No stage drops or duplicates data.
- Outputs hold stable while out_valid & !out_ready.
- Reset:
  - All valid flags clear, and all data registers and outputs become 0 in the cycle after rst is sampled high.
  - in_ready = 1 during and after reset.
  - In-flight data is discarded by a mid-operation reset.
- Simultaneous accept and output: with the pipeline full and out_ready = 1, a new input is accepted in the same cycle.

## Configuration
- FP_SWAP_GRS_EN defined: small_grs is computed as above.
- Not defined:
  - small_grs is tied to 3'b000.
  - Shifted-out bits are discarded.
  - The shift saturates at MANT_W+1.
  - The shifter logic for the extra 3 bits is not synthesised.

## Structure
- Shared package fp_pkg holds:
  - a typedef of the unpacked operand struct {sign, exp[EXP_W], mant[MANT_W]}
  - a typedef of the aligned-pair output struct
  - a localparam GRS_W = 3
  - a function that computes the hidden bit
- Sub-module fp_align_shift (combinational barrel shifter with sticky, parametrised on width) is used by S2.
- The handshake logic stays in the top module.

## Test plan
- A = 6.9 (0 / 0x81 / 0x5CCCCD), B = 4.2 (0 / 0x81 / 0x066666), sub = 0 -> swapped = 0, eff_sub = 0, big_exp = 0x81, small_sig = 0x866666, grs = 000, out_valid 2 cycles after accept.
- A = 0.69 (0 / 0x7E / 0x30A3D7), B = 4.2, sub = 0 -> swapped = 1, big_exp = 0x81, big_sig = 0x866666, d = 3, small_sig = 0x1614 7A (0xB0A3D7 >> 3 = 0x16147A), grs = 111.
- Same operands, sub = 1 -> swapped = 1, big_sign = 1, eff_sub = 1.
- exp_A = 0xFE, exp_B = 0x01, mant_B ≠ 0:
  - with FP_SWAP_GRS_EN: small_sig = 0, grs = 001
  - without it: small_sig = 0, grs = 000
- Stream of 8 back-to-back pairs, out_ready low for 3 cycles mid-stream -> in_ready drops after both stages fill, outputs held stable, all 8 results delivered in order.
- rst asserted with both stages valid -> next cycle out_valid = 0, all outputs 0, in_ready = 1.
